// File: rtl/rice_core_id_buffer.sv
// -----------------------------------------------------------------------------
// rice_core_id_buffer
//
// Purpose:
//   DEPTH-entry instruction queue between the IF stage and the ID decoder.
//   Each instruction is pre-decoded as it is written. The decoded fields are
//   rs1/rs2/rd with gating by format, plus the sign-extended immediate. They
//   are stored alongside the PC and the raw instruction. The queue head is
//   presented to the decoder together with a live occupancy count.
//
// Optional feature (macro RICE_CORE_ID_BUFFER_BYPASS_EN):
//   When defined, an empty queue forwards a valid fetch to the ID outputs in
//   the same cycle, using a combinational pre-decode. If ID accepts it in that
//   cycle, the instruction is never written into the queue. When the macro is
//   undefined, an instruction always takes one cycle to reach the outputs, and
//   there is no combinational path from the IF inputs to the ID outputs.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_enable            core enable; low behaves exactly like i_flush
//   i_flush             discard every entry (branch/trap redirect)
//   i_if_valid/pc/inst  fetch side producer
//   o_if_ready          queue can accept (count != DEPTH)
//   o_id_valid/pc/inst  head entry presented to the decoder
//   o_id_rs1/rs2/rd     gated register indices of the head
//   o_id_imm            sign-extended immediate of the head
//   i_id_ready          decoder consumes the head
//   o_count             occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module rice_core_id_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_flush,
  input  logic             i_if_valid,
  input  logic [XLEN-1:0]  i_if_pc,
  input  logic [31:0]      i_if_inst,
  output logic             o_if_ready,
  output logic             o_id_valid,
  output logic [XLEN-1:0]  o_id_pc,
  output logic [31:0]      o_id_inst,
  output logic [4:0]       o_id_rs1,
  output logic [4:0]       o_id_rs2,
  output logic [4:0]       o_id_rd,
  output logic [XLEN-1:0]  o_id_imm,
  input  logic             i_id_ready,
  output logic [PTR_W:0]   o_count
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  // Opcode map used for the R/I/S/B/U/J classification.
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
  } entry_t;

  // Pre-decode. Any opcode that is not listed is treated as R-type: all three
  // register indices pass through and the immediate is 0.
  function automatic entry_t predecode(input logic [XLEN-1:0] pc,
                                       input logic [31:0]     inst);
    entry_t      e;
    logic [31:0] imm32;
    e.pc   = pc;
    e.inst = inst;
    e.rs1  = inst[19:15];
    e.rs2  = inst[24:20];
    e.rd   = inst[11:7];
    imm32  = '0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_OP_IMM32, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
        e.rs2 = '0;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        e.rd  = '0;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        e.rd  = '0;
        imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        e.rs1 = '0;
        e.rs2 = '0;
        imm32 = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        e.rs1 = '0;
        e.rs2 = '0;
        imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: begin
        imm32 = '0;
      end
    endcase
    // The 32-bit immediate is already sign-extended, so widening it as a
    // signed value gives the correct upper bits when XLEN=64.
    e.imm = XLEN'(signed'(imm32));
    return e;
  endfunction

  // Handshake rules:
  //   A transfer happens on a side only in a cycle where both valid and ready
  //   are high at the clock edge. o_if_ready depends only on the registered
  //   count, so there is no combinational path from ID back to IF. While
  //   o_id_valid is high, the head stays stable until it is consumed, a flush
  //   occurs, or reset is applied.

  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  entry_t           mem_q [DEPTH];

  logic   flush;
  logic   q_valid;
  logic   enq_req;
  logic   wr_en;
  logic   deq_mem;
  logic   bypass_consume;
  entry_t in_entry;
  entry_t head;
  entry_t out_entry;

  assign flush    = i_flush | ~i_enable;
  assign q_valid  = (count_q != '0);
  assign in_entry = predecode(i_if_pc, i_if_inst);
  assign head     = mem_q[rd_ptr_q];

  assign o_if_ready = (count_q != FULL_COUNT);
  assign enq_req    = i_if_valid & o_if_ready;

`ifdef RICE_CORE_ID_BUFFER_BYPASS_EN
  logic bypass_act;
  // Forward the fetch directly only when nothing older is queued and no
  // flush is in progress.
  assign bypass_act     = ~q_valid & i_if_valid & ~flush;
  assign bypass_consume = bypass_act & i_id_ready;
  assign o_id_valid     = q_valid | bypass_act;

  always_comb begin
    out_entry = '0;
    if (bypass_act) begin
      out_entry = in_entry;
    end else if (q_valid) begin
      out_entry = head;
    end
  end
`else
  assign bypass_consume = 1'b0;
  assign o_id_valid     = q_valid;

  always_comb begin
    out_entry = '0;
    if (q_valid) begin
      out_entry = head;
    end
  end
`endif

  // A flush discards any enqueue or dequeue that happens in the same cycle.
  assign wr_en   = enq_req & ~flush & ~bypass_consume;
  assign deq_mem = q_valid & i_id_ready & ~flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (wr_en)   wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (deq_mem) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_en, deq_mem})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage is not reset. The outputs are zeroed whenever o_id_valid
  // is low, so stale contents are never visible.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign o_id_pc   = out_entry.pc;
  assign o_id_inst = out_entry.inst;
  assign o_id_rs1  = out_entry.rs1;
  assign o_id_rs2  = out_entry.rs2;
  assign o_id_rd   = out_entry.rd;
  assign o_id_imm  = out_entry.imm;
  assign o_count   = count_q;

`ifndef SYNTHESIS
  a_no_enq_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    wr_en |-> (count_q != FULL_COUNT));
  a_no_deq_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    deq_mem |-> (count_q != '0));
  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count_q <= FULL_COUNT);
`endif

endmodule

// File: tb/tb_rice_core_id_buffer.sv
// -----------------------------------------------------------------------------
// tb_rice_core_id_buffer
//
// Bench for rice_core_id_buffer, configured with XLEN=64 and DEPTH=4.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// later and compared against a queue-based reference model. The model is
// then advanced according to the handshake that occurs at the next rising
// edge.
// -----------------------------------------------------------------------------
module tb_rice_core_id_buffer;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             enable;
  logic             flush;
  logic             if_valid;
  logic [XLEN-1:0]  if_pc;
  logic [31:0]      if_inst;
  logic             if_ready;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [31:0]      id_inst;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]  id_imm;
  logic             id_ready;
  logic [PTR_W:0]   count;

  rice_core_id_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enable   (enable),
    .i_flush    (flush),
    .i_if_valid (if_valid),
    .i_if_pc    (if_pc),
    .i_if_inst  (if_inst),
    .o_if_ready (if_ready),
    .o_id_valid (id_valid),
    .o_id_pc    (id_pc),
    .o_id_inst  (id_inst),
    .o_id_rs1   (id_rs1),
    .o_id_rs2   (id_rs2),
    .o_id_rd    (id_rd),
    .o_id_imm   (id_imm),
    .i_id_ready (id_ready),
    .o_count    (count)
  );

  // ---------------- scoreboard ----------------
  logic [XLEN+31:0] exp_q[$];   // {pc, inst} in arrival order
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference decode ----------------
  // Format codes: 0=R 1=I 2=S 3=B 4=U 5=J
  function automatic int fmt_of(input logic [6:0] op);
    case (op)
      7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h0F: return 1;
      7'h23: return 2;
      7'h63: return 3;
      7'h37, 7'h17: return 4;
      7'h6F: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] inst);
    logic [11:0] f12;
    logic [12:0] f13;
    logic [20:0] f21;
    logic [19:0] f20;
    case (fmt_of(inst[6:0]))
      1: begin f12 = inst[31:20]; return longint'($signed(f12)); end
      2: begin f12 = {inst[31:25], inst[11:7]}; return longint'($signed(f12)); end
      3: begin f13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
               return longint'($signed(f13)); end
      4: begin f20 = inst[31:12]; return longint'($signed(f20)) * 64'sd4096; end
      5: begin f21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
               return longint'($signed(f21)); end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [4:0] ref_rs1(input logic [31:0] inst);
    int f;
    f = fmt_of(inst[6:0]);
    return (f == 4 || f == 5) ? 5'd0 : inst[19:15];
  endfunction

  function automatic logic [4:0] ref_rs2(input logic [31:0] inst);
    int f;
    f = fmt_of(inst[6:0]);
    return (f == 0 || f == 2 || f == 3) ? inst[24:20] : 5'd0;
  endfunction

  function automatic logic [4:0] ref_rd(input logic [31:0] inst);
    int f;
    f = fmt_of(inst[6:0]);
    return (f == 2 || f == 3) ? 5'd0 : inst[11:7];
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    r = $urandom();
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  // ---------------- driver: one cycle with check + model update ----------------
  task automatic step(input logic v, input logic [XLEN-1:0] pc, input logic [31:0] inst,
                      input logic idr, input logic fl, input logic en);
    int               sz;
    logic             byp, kill, e_valid, e_ready;
    logic [XLEN-1:0]  e_pc;
    logic [31:0]      e_inst;
    logic [XLEN+31:0] hd;
    @(negedge clk);
    if_valid = v; if_pc = pc; if_inst = inst; id_ready = idr; flush = fl; enable = en;
    #1;
    sz   = exp_q.size();
    kill = fl || !en;
    byp  = 1'b0;
`ifdef RICE_CORE_ID_BUFFER_BYPASS_EN
    byp  = (sz == 0) && v && !kill;
`endif
    e_ready = (sz != DEPTH);
    e_valid = (sz != 0) || byp;
    e_pc    = '0;
    e_inst  = '0;
    if (byp) begin
      e_pc = pc; e_inst = inst;
    end else if (sz != 0) begin
      hd = exp_q[0]; e_pc = hd[XLEN+31:32]; e_inst = hd[31:0];
    end
    check("id_valid", id_valid, e_valid);
    check("if_ready", if_ready, e_ready);
    check("count",    count,    sz);
    check("id_pc",    id_pc,    e_pc);
    check("id_inst",  id_inst,  e_inst);
    check("id_rs1",   id_rs1,   e_valid ? ref_rs1(e_inst) : 5'd0);
    check("id_rs2",   id_rs2,   e_valid ? ref_rs2(e_inst) : 5'd0);
    check("id_rd",    id_rd,    e_valid ? ref_rd(e_inst)  : 5'd0);
    check("id_imm",   id_imm,   e_valid ? ref_imm(e_inst) : 64'd0);
    if (kill) begin
      exp_q.delete();
    end else if (!(byp && idr)) begin
      if (e_valid && idr) void'(exp_q.pop_front());
      if (v && e_ready) exp_q.push_back({pc, inst});
    end
  endtask

  // Idle for one cycle and compare the head against constants from the test plan.
  task automatic hold_check(input string tag, input logic [63:0] imm,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    @(negedge clk);
    if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0; enable = 1'b1;
    #1;
    check({tag, "_valid"}, id_valid, 1'b1);
    check({tag, "_imm"},   id_imm,   imm);
    check({tag, "_rs1"},   id_rs1,   rs1);
    check({tag, "_rs2"},   id_rs2,   rs2);
    check({tag, "_rd"},    id_rd,    rd);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0; enable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", id_valid, 1'b0);
    check("arst_count", count,    0);
    check("arst_ready", if_ready, 1'b1);
    check("arst_pc",    id_pc,    64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    enable = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;
    #1;
    check("rst_valid", id_valid, 1'b0);
    check("rst_ready", if_ready, 1'b1);
    check("rst_count", count,    0);
    check("rst_inst",  id_inst,  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x0,5 at pc 0x100
    step(1'b1, 64'h100, 32'h00500093, 1'b0, 1'b0, 1'b1);
    hold_check("addi", 64'd5, 5'd0, 5'd0, 5'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // fill past full with the decoder stalled, then drain in order
    for (int i = 0; i < 5; i++) step(1'b1, 64'(i * 4), rand_inst(), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // steady state with two entries queued; pointers wrap several times
    for (int i = 0; i < 2; i++) step(1'b1, 64'(32'h200 + i * 4), rand_inst(), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 64'(32'h300 + i * 4), rand_inst(), 1'b1, 1'b0, 1'b1);

    // grow to three entries, flush with a concurrent fetch, then disable-flush
    step(1'b1, 64'h400, rand_inst(), 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'hBAD0, 32'h00700113, 1'b1, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 64'h500, rand_inst(), 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'hBAD4, rand_inst(), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // immediate decode at XLEN=64
    step(1'b1, 64'h600, 32'hFE000EE3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'h604, 32'h800000B7, 1'b0, 1'b0, 1'b1);
    hold_check("beq", 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0, 5'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    hold_check("lui", 64'hFFFF_FFFF_8000_0000, 5'd0, 5'd0, 5'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // empty queue, fetch with decoder ready, then with decoder stalled
    step(1'b1, 64'h700, rand_inst(), 1'b1, 1'b0, 1'b1);
    step(1'b1, 64'h704, rand_inst(), 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // asynchronous reset with entries queued
    step(1'b1, 64'h800, rand_inst(), 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'h804, rand_inst(), 1'b0, 1'b0, 1'b1);
    async_reset_check();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 64'({$urandom(), $urandom()}), rand_inst(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 30) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
